// File: rtl/keccak_digest_collector_if.sv
// Stream bundle between the Keccak squeeze port, the collector and the host/DMA side.
// slave = collector view, master = environment (core + consumer) view.
interface keccak_digest_collector_if #(
   parameter int DATA_W = 32
);
   logic                  in_valid;
   logic [DATA_W-1:0]     in_data;
   logic                  in_ready;
   logic                  out_valid;
   logic [DATA_W-1:0]     out_data;
   logic [DATA_W/8-1:0]   out_keep;
   logic                  out_last;
   logic                  out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );
endinterface

// File: rtl/keccak_digest_collector.sv
// Collects one digest worth of squeezed Keccak words into a FIFO and re-emits them with keep/last.
// Optional statistics counters (digest_cnt, stall_cnt) are enabled by defining KDC_STATS_EN.
module keccak_digest_collector #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int D_W    = 11
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_start,
   input  logic [2:0]             i_cmode,
   input  logic [D_W-1:0]         i_d,
   input  logic                   i_abort,
   keccak_digest_collector_if.slave bus,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_err,
   output logic [$clog2(DEPTH):0] o_level
`ifdef KDC_STATS_EN
   ,
   output logic [15:0]            o_digest_cnt,
   output logic [15:0]            o_stall_cnt
`endif
);
   localparam int KEEP_W = DATA_W / 8;
   localparam int AW     = $clog2(DEPTH);
   localparam int LW     = AW + 1;
   localparam int NB_W   = (D_W > 10) ? D_W : 10;
   localparam int DW_SH  = $clog2(DATA_W);
   localparam int ENT_W  = DATA_W + KEEP_W + 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;

   logic [1:0]        r_state;
   logic [NB_W-1:0]   r_nwords;
   logic [NB_W-1:0]   r_wcnt;
   logic [KEEP_W-1:0] r_last_keep;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic              r_done;
   logic              r_err;
   logic [ENT_W-1:0]  r_mem [DEPTH];

   logic [NB_W-1:0]   w_nbits;
   logic              w_mode_ok;
   logic              w_start_ok;
   logic [DW_SH-1:0]  w_rem;
   logic [DW_SH:0]    w_rem_bytes;
   logic [NB_W-1:0]   w_nwords;
   logic [KEEP_W-1:0] w_keep;
   logic [NB_W-1:0]   w_wcnt_inc;
   logic              w_is_last;
   logic              w_full;
   logic              w_in_ready;
   logic              w_out_valid;
   logic              w_push;
   logic              w_pop;
   logic [ENT_W-1:0]  w_head;
   logic              w_head_last;
   logic              w_done_set;

   always_comb begin
      w_nbits   = '0;
      w_mode_ok = 1'b1;
      case (i_cmode)
         3'd0:       w_nbits = NB_W'(224);
         3'd1:       w_nbits = NB_W'(256);
         3'd2:       w_nbits = NB_W'(384);
         3'd3:       w_nbits = NB_W'(512);
         3'd4, 3'd5: w_nbits = NB_W'(i_d);
         default:    w_mode_ok = 1'b0;
      endcase
   end

   assign w_start_ok  = w_mode_ok && (w_nbits != '0);
   assign w_rem       = w_nbits[DW_SH-1:0];
   assign w_nwords    = (w_nbits >> DW_SH) + NB_W'(w_rem != '0);
   // A trailing partial byte still counts as a kept byte.
   assign w_rem_bytes = ({1'b0, w_rem} + (DW_SH+1)'(7)) >> 3;

   genvar gi;
   generate
      for (gi = 0; gi < KEEP_W; gi++) begin : g_keep
         assign w_keep[gi] = (w_rem == '0) || ((DW_SH+1)'(gi) < w_rem_bytes);
      end
   endgenerate

   assign w_full      = (r_level == LW'(DEPTH));
   assign w_in_ready  = (r_state == S_COLLECT) && !w_full;
   assign w_out_valid = (r_level != '0);
   assign w_push      = !i_abort && w_in_ready && bus.in_valid;
   assign w_pop       = !i_abort && w_out_valid && bus.out_ready;
   assign w_wcnt_inc  = r_wcnt + NB_W'(1);
   assign w_is_last   = (w_wcnt_inc == r_nwords);
   assign w_head      = r_mem[r_rd_ptr];
   assign w_head_last = w_head[ENT_W-1];
   assign w_done_set  = w_pop && w_head_last && (r_state == S_DRAIN);

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= {w_is_last, (w_is_last ? r_last_keep : {KEEP_W{1'b1}}), bus.in_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_nwords    <= '0;
         r_wcnt      <= '0;
         r_last_keep <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (i_abort) begin
            r_state  <= S_IDLE;
            r_wcnt   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
               r_wcnt   <= w_wcnt_inc;
            end
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
               2'b10:   r_level <= r_level + LW'(1);
               2'b01:   r_level <= r_level - LW'(1);
               default: r_level <= r_level;
            endcase
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     if (w_start_ok) begin
                        r_nwords    <= w_nwords;
                        r_last_keep <= w_keep;
                        r_wcnt      <= '0;
                        r_state     <= S_COLLECT;
                     end else begin
                        r_err <= 1'b1;
                     end
                  end
               end
               S_COLLECT: begin
                  r_err <= i_start;
                  if (w_push && w_is_last)
                     r_state <= S_DRAIN;
               end
               S_DRAIN: begin
                  r_err <= i_start;
                  if (w_done_set) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef KDC_STATS_EN
   logic [15:0] r_digest_cnt;
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digest_cnt <= '0;
         r_stall_cnt  <= '0;
      end else begin
         if (w_done_set)
            r_digest_cnt <= r_digest_cnt + 16'd1;
         if ((r_state == S_COLLECT) && bus.in_valid && !w_in_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign o_digest_cnt = r_digest_cnt;
   assign o_stall_cnt  = r_stall_cnt;
`endif

   // Head entry is exposed only while valid so idle outputs read as zero.
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_valid ? w_head[DATA_W-1:0] : '0;
   assign bus.out_keep  = w_out_valid ? w_head[DATA_W +: KEEP_W] : '0;
   assign bus.out_last  = w_out_valid && w_head_last;
   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = r_done;
   assign o_err         = r_err;
   assign o_level       = r_level;
endmodule

// File: tb/tb_keccak_digest_collector.sv
// Directed bench for keccak_digest_collector (DATA_W=32, DEPTH=16, D_W=11).
// Stats checks are compiled in when KDC_STATS_EN is defined.
module tb_keccak_digest_collector;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  cmode = 3'd0;
   logic [10:0] d = 11'd0;
   logic        abort = 1'b0;
   logic        busy, done, err;
   logic [4:0]  level;
`ifdef KDC_STATS_EN
   logic [15:0] digest_cnt, stall_cnt;
`endif

   int n_total = 0;
   int n_bad   = 0;
   int exp_digests = 0;

   keccak_digest_collector_if #(.DATA_W(32)) bus ();

   keccak_digest_collector #(.DATA_W(32), .DEPTH(16), .D_W(11)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (start),
      .i_cmode (cmode),
      .i_d     (d),
      .i_abort (abort),
      .bus     (bus),
      .o_busy  (busy),
      .o_done  (done),
      .o_err   (err),
      .o_level (level)
`ifdef KDC_STATS_EN
      ,
      .o_digest_cnt (digest_cnt),
      .o_stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_digest(input logic [2:0] m, input logic [10:0] dl);
      start = 1'b1;
      cmode = m;
      d     = dl;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push(input int n, input logic [31:0] base, input string tag);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_in_ready"}, bus.in_ready, 1);
         bus.in_valid = 1'b1;
         bus.in_data  = base + i;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int n, input logic [31:0] base, input logic [3:0] lkeep, input string tag);
      bus.out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         chk({tag, "_valid"}, bus.out_valid, 1);
         chk({tag, "_data"}, bus.out_data, base + i);
         chk({tag, "_keep"}, bus.out_keep, (i == n - 1) ? lkeep : 4'hF);
         chk({tag, "_last"}, bus.out_last, (i == n - 1) ? 1 : 0);
         $display("%s pop %0d data=0x%08h keep=0x%h last=%0d", tag, i, bus.out_data, bus.out_keep, bus.out_last);
         @(negedge clk);
      end
      bus.out_ready = 1'b0;
      exp_digests++;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_level_after"}, level, 0);
      @(negedge clk);
      chk({tag, "_done_clear"}, done, 0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_out_keep", bus.out_keep, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_level", level, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // SHA3-256 streaming with out_ready held high
      start_digest(3'd1, 11'd0);
      bus.out_ready = 1'b1;
      chk("t1_busy", busy, 1);
      for (int i = 1; i <= 9; i++) begin
         if (i == 1) begin
            chk("t1_empty", bus.out_valid, 0);
         end else begin
            chk("t1_valid", bus.out_valid, 1);
            chk("t1_data", bus.out_data, i - 1);
            chk("t1_keep", bus.out_keep, 4'hF);
            chk("t1_last", bus.out_last, (i == 9) ? 1 : 0);
            chk("t1_level", level, 1);
            $display("t1 pop data=0x%08h last=%0d", bus.out_data, bus.out_last);
         end
         if (i <= 8) begin
            chk("t1_in_ready", bus.in_ready, 1);
            bus.in_valid = 1'b1;
            bus.in_data  = i;
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b0;
      exp_digests++;
      chk("t1_done", done, 1);
      chk("t1_busy_after", busy, 0);
      chk("t1_out_valid_after", bus.out_valid, 0);
      @(negedge clk);
      chk("t1_done_clear", done, 0);

      // SHAKE128 d=100: 4 words, last keep 0x1, 5th word refused
      start_digest(3'd4, 11'd100);
      push(4, 32'h000000A1, "t2");
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h000000A5;
      chk("t2_5th_ready", bus.in_ready, 0);
      @(negedge clk);
      chk("t2_level", level, 4);
      bus.in_valid = 1'b0;
      drain(4, 32'h000000A1, 4'h1, "t2");

      // SHA3-512 fills the FIFO exactly with out_ready low
      start_digest(3'd3, 11'd0);
      push(16, 32'h00000100, "t3");
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h00000999;
      for (int i = 0; i < 2; i++) begin
         chk("t3_level_full", level, 16);
         chk("t3_in_ready", bus.in_ready, 0);
         chk("t3_hold_data", bus.out_data, 32'h00000100);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      drain(16, 32'h00000100, 4'hF, "t3");

      // Rejected starts: invalid mode, SHAKE d=0, start while busy
      start_digest(3'd6, 11'd0);
      chk("t4_err_mode", err, 1);
      chk("t4_idle_mode", busy, 0);
      @(negedge clk);
      chk("t4_err_clear", err, 0);
      start_digest(3'd5, 11'd0);
      chk("t4_err_d0", err, 1);
      chk("t4_idle_d0", busy, 0);
      start_digest(3'd0, 11'd0);
      chk("t4_busy", busy, 1);
      chk("t4_no_err", err, 0);
      push(3, 32'h00000200, "t4a");
      start_digest(3'd1, 11'd0);
      chk("t4_err_busy", err, 1);
      chk("t4_still_busy", busy, 1);
      push(4, 32'h00000203, "t4b");
      chk("t4_drain_ready", bus.in_ready, 0);
      chk("t4_level", level, 7);
      drain(7, 32'h00000200, 4'hF, "t4");

      // Abort SHA3-384 after 3 words with 2 buffered; start alongside must not err
      start_digest(3'd2, 11'd0);
      push(3, 32'h00000300, "t5");
      bus.out_ready = 1'b1;
      chk("t5_head", bus.out_data, 32'h00000300);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("t5_level2", level, 2);
      chk("t5_head2", bus.out_data, 32'h00000301);
      abort = 1'b1;
      start = 1'b1;
      cmode = 3'd0;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      chk("t5_level0", level, 0);
      chk("t5_out_valid", bus.out_valid, 0);
      chk("t5_out_data", bus.out_data, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_err", err, 0);
      @(negedge clk);
      chk("t5_done_late", done, 0);
      start_digest(3'd0, 11'd0);
      push(7, 32'h00000400, "t5b");
      chk("t5b_in_ready", bus.in_ready, 0);
      drain(7, 32'h00000400, 4'hF, "t5b");

      // SHAKE256 d=1024 (32 words): fill 16, then 5 stall cycles, then abort
      start_digest(3'd5, 11'd1024);
      push(16, 32'h00000500, "t6");
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'h00000510;
         chk("t6_stall_ready", bus.in_ready, 0);
         chk("t6_stall_level", level, 16);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("t6_busy", busy, 1);
`ifdef KDC_STATS_EN
      chk("t6_stall_cnt", stall_cnt, 5);
      chk("t6_digest_cnt", digest_cnt, exp_digests);
`endif
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t6_abort_level", level, 0);
      chk("t6_abort_busy", busy, 0);
      chk("t6_abort_done", done, 0);
`ifdef KDC_STATS_EN
      chk("t6_stall_kept", stall_cnt, 5);
      chk("t6_digest_kept", digest_cnt, exp_digests);
`endif

      // Asynchronous reset mid-digest
      start_digest(3'd1, 11'd0);
      push(2, 32'h00000600, "t7");
      chk("t7_level", level, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_rst_level", level, 0);
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_valid", bus.out_valid, 0);
      chk("t7_rst_ready", bus.in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("t7_rst_done", done, 0);
      @(negedge clk);
      chk("t7_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/keccak_digest_collector.md
Name: keccak_digest_collector

Overview:
- Synthesizable successor to the simulation-only digest dump: captures the Keccak core's squeezed output words for one digest and buffers them in an internal FIFO.
- Re-emits them on a valid/ready stream with last-word marking and byte-keep masking.
- Generalised in word width, FIFO depth and output length (SHA3-224/256/384/512, SHAKE128/256 with arbitrary d).
- Sits between the Keccak squeeze port and the host/DMA interface.

Parameters:
DATA_W, 32, width of input and output data words; multiple of 8, 32 or 64
DEPTH, 16, FIFO depth in words; power of two, at least 2
D_W, 11, width of the SHAKE output length input d, in bits

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin a digest; samples cmode and d
cmode  in  3  0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512, 4=SHAKE128, 5=SHAKE256, 6/7 invalid
d  in  D_W  SHAKE output length in bits (modes 4/5 only)
abort  in  1  cancel the current digest and flush
in_valid  in  1  core output word valid
in_data  in  DATA_W  core output word; byte 0 = in_data[7:0]
in_ready  out  1  collector accepts a word
out_valid  out  1  output word valid
out_data  out  DATA_W  output word
out_keep  out  DATA_W/8  valid-byte mask for out_data
out_last  out  1  final word of the digest
out_ready  in  1  consumer accepts a word
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse: last word of the digest popped
err  out  1  one-cycle pulse: rejected start
level  out  $clog2(DEPTH)+1  FIFO occupancy in words

Behaviour:
- Reset values: state IDLE, FIFO empty, all counters 0; in_ready, out_valid, out_last, busy, done, err and level are 0; out_keep and out_data are 0.
- Digest length nbits: 224, 256, 384 or 512 for modes 0-3; d for modes 4/5.
- Word count: nwords = ceil(nbits/DATA_W).
- Remainder: rem = nbits mod DATA_W.
- Last-word keep mask: all ones if rem==0, else (1<<ceil(rem/8))-1. A partial byte counts as a kept byte. All non-last words have keep all ones.
- The keep mask and last flag are computed at word acceptance and stored per FIFO entry alongside the data.
- State machine IDLE, COLLECT and DRAIN:
  - IDLE: on start, a valid mode and nbits>0, latch nwords and keep, clear the word counter, go to COLLECT.
  - IDLE: on start with cmode 6/7, or mode 4/5 with d==0, pulse err next cycle and stay in IDLE.
  - COLLECT: in_ready = !full. A word is accepted on in_valid&&in_ready and the word counter increments. Accepting word nwords goes to DRAIN.
  - DRAIN: in_ready=0. Popping the entry with out_last set pulses done for one cycle and goes to IDLE.
- start while busy is ignored and err pulses for one cycle; the running digest is unaffected.
- FIFO output:
  - A word accepted at edge N gives out_valid=1 after edge N (1-cycle latency).
  - A pop occurs on out_valid&&out_ready.
  - Push and pop in the same cycle are both performed; level is unchanged.
  - When full, in_ready=0; there is no full-bypass.
  - Output signals hold stable while out_valid&&!out_ready.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH.
- abort, in any state and at higher priority than start, push or pop: next cycle the state is IDLE, the FIFO is empty, out_valid=0, and neither done nor err pulses.
- Asserting rst_n low mid-digest clears everything immediately; no done pulse.
- in_valid outside COLLECT is ignored; no error.

Optional Feature:
- Macro KDC_STATS_EN.
- When defined:
  - Adds output digest_cnt[15:0], which increments on each done pulse and wraps 0xFFFF->0.
  - Adds output stall_cnt[15:0], which counts cycles with in_valid&&!in_ready in COLLECT and saturates at 0xFFFF.
  - Both reset to 0; abort does not clear them.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- SHA3-256, DATA_W=32, out_ready=1, 8 words 0x00000001..0x00000008 back-to-back -> 8 outputs in order, out_keep=0xF each, out_last only on 0x00000008, done one cycle after that pop, busy=0 after.
- SHAKE128 with d=100, DATA_W=32 -> nwords=4; out_last on word 4 with out_keep=0x1; 5th in_valid word not accepted (in_ready=0).
- SHA3-512 with DEPTH=16 and out_ready=0 -> 16 accepted, level=16, in_ready=0. Raise out_ready -> 16 pops, last flagged, done pulses.
- start with cmode=6, then start during COLLECT of SHA3-224 -> err pulses each time; the SHA3-224 digest still completes 7 words with done.
- abort after 3 of 12 SHA3-384 words with 2 in the FIFO -> next cycle level=0, out_valid=0, busy=0, no done; a following SHA3-224 runs cleanly.
- With KDC_STATS_EN, 3 digests plus 5 full-stall cycles -> digest_cnt=3, stall_cnt=5; abort leaves both unchanged.
